// File: rtl/bsg_two_entry_fifo_pkg.sv
// Shared definitions for the two-entry FIFO and its storage.
//
// Contents:
//   bsg_two_entry_depth_lp - number of storage entries (fixed at two)
//   ptr_t                  - one-bit entry pointer type
//   toggle_ptr()           - advance a pointer; wrap is a plain bit flip
package bsg_two_entry_fifo_pkg;

    localparam int bsg_two_entry_depth_lp = 2;

    typedef logic ptr_t;

    function automatic ptr_t toggle_ptr(input ptr_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/bsg_two_entry_mem.sv
// Two-entry register file with one write port and one asynchronous read port.
// Contents are never reset; the first write of each entry defines it.
//
// Ports:
//   clk_i     - clock, writes land on posedge
//   w_v_i     - write enable
//   w_addr_i  - write entry select
//   w_data_i  - write data
//   r_addr_i  - read entry select
//   r_data_o  - combinational read data
module bsg_two_entry_mem
    import bsg_two_entry_fifo_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               w_v_i,
    input  ptr_t               w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  ptr_t               r_addr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [width_p-1:0] mem_q [bsg_two_entry_depth_lp];
    logic [width_p-1:0] mem_d [bsg_two_entry_depth_lp];

    always_comb begin
        mem_d = mem_q;
        if (w_v_i) begin
            mem_d[w_addr_i] = w_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bsg_two_entry_fifo.sv
// Two-entry registered-status FIFO used as a retiming/decoupling buffer.
// ready_o and v_o come straight from flops, so neither depends
// combinationally on any input; this breaks the path from the consumer's
// yumi logic back to the producer.
//
// Ports:
//   clk_i    - clock, all state updates on posedge
//   reset_i  - synchronous active-high reset
//   v_i      - producer has valid data on data_i
//   data_i   - write data
//   ready_o  - FIFO can accept data (not full), registered
//   v_o      - data_o is valid (not empty), registered
//   data_o   - head entry
//   yumi_i   - consumer takes the head this cycle (legal only while v_o=1)
module bsg_two_entry_fifo
    import bsg_two_entry_fifo_pkg::*;
#(
    parameter int width_p                 = 8,
    parameter bit allow_enq_deq_on_full_p = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    logic empty_q, empty_d;
    logic full_q, full_d;
    logic enq, deq;

    // An illegal yumi on an empty FIFO is masked so it cannot disturb state.
    // With allow_enq_deq_on_full_p the slot freed by this cycle's dequeue
    // may be refilled immediately, so the write port reuses it.
    always_comb begin
        deq = yumi_i & ~empty_q;
        if (allow_enq_deq_on_full_p) begin
            enq = v_i & (~full_q | deq);
        end else begin
            enq = v_i & ~full_q;
        end
    end

    // Occupancy 1 is exactly "neither empty nor full", which lets the
    // enq-only and deq-only cases derive the new flag from the opposite one.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        empty_d = empty_q;
        full_d  = full_q;
        if (reset_i) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            empty_d = 1'b1;
            full_d  = 1'b0;
        end else begin
            if (enq) begin
                tail_d = toggle_ptr(tail_q);
            end
            if (deq) begin
                head_d = toggle_ptr(head_q);
            end
            if (enq && !deq) begin
                empty_d = 1'b0;
                full_d  = ~empty_q;
            end else if (deq && !enq) begin
                full_d  = 1'b0;
                empty_d = ~full_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        empty_q <= empty_d;
        full_q  <= full_d;
    end

    bsg_two_entry_mem #(
        .width_p(width_p)
    ) mem (
        .clk_i   (clk_i),
        .w_v_i   (enq & ~reset_i),
        .w_addr_i(tail_q),
        .w_data_i(data_i),
        .r_addr_i(head_q),
        .r_data_o(data_o)
    );

    assign ready_o = ~full_q;
    assign v_o     = ~empty_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && empty_q))
                else $error("bsg_two_entry_fifo: yumi_i asserted while v_o=0");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_two_entry_fifo.sv
// Directed and random checks for bsg_two_entry_fifo. Two instances run side
// by side: dut0 with allow_enq_deq_on_full_p=0 and dut1 with it set to 1.
module tb_bsg_two_entry_fifo;

    logic       clk = 1'b0;
    logic       reset0, reset1;
    logic       v_i;
    logic [7:0] data_i;
    logic       yumi0, yumi1;
    logic       ready0, v0, ready1, v1;
    logic [7:0] data0, data1;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    bsg_two_entry_fifo #(.width_p(8), .allow_enq_deq_on_full_p(1'b0)) dut0 (
        .clk_i(clk), .reset_i(reset0), .v_i(v_i), .data_i(data_i),
        .ready_o(ready0), .v_o(v0), .data_o(data0), .yumi_i(yumi0)
    );

    bsg_two_entry_fifo #(.width_p(8), .allow_enq_deq_on_full_p(1'b1)) dut1 (
        .clk_i(clk), .reset_i(reset1), .v_i(v_i), .data_i(data_i),
        .ready_o(ready1), .v_o(v1), .data_o(data1), .yumi_i(yumi1)
    );

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d,
                                 input logic y0, input logic y1);
        reset0 = r;
        reset1 = r;
        v_i    = v;
        data_i = d;
        yumi0  = y0;
        yumi1  = y1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset0 = 1'b1; reset1 = 1'b1; v_i = 1'b0; data_i = 8'h00;
        yumi0 = 1'b0; yumi1 = 1'b0;

        // Reset for two cycles, then idle.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst_v0", 8'(v0), 8'h0);
        checkOutput("rst_ready0", 8'(ready0), 8'h1);
        checkOutput("rst_v1", 8'(v1), 8'h0);
        checkOutput("rst_ready1", 8'(ready1), 8'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("idle_v0", 8'(v0), 8'h0);
        checkOutput("idle_ready0", 8'(ready0), 8'h1);

        // Fill and drain.
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("fill1_v0", 8'(v0), 8'h1);
        checkOutput("fill1_ready0", 8'(ready0), 8'h1);
        checkOutput("fill1_data0", data0, 8'hA5);
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        checkOutput("full_ready0", 8'(ready0), 8'h0);
        checkOutput("full_v0", 8'(v0), 8'h1);
        checkOutput("full_data0", data0, 8'hA5);
        checkOutput("full_ready1", 8'(ready1), 8'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("drain1_data0", data0, 8'h3C);
        checkOutput("drain1_ready0", 8'(ready0), 8'h1);
        checkOutput("drain1_v0", 8'(v0), 8'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("drain2_v0", 8'(v0), 8'h0);
        checkOutput("drain2_v1", 8'(v1), 8'h0);

        // Streaming: one word per cycle after a single cycle of latency.
        for (int t = 0; t <= 16; t++) begin
            v_i    = (t < 16);
            data_i = 8'(t);
            yumi0  = (t >= 1);
            yumi1  = (t >= 1);
            if (t >= 1) begin
                checkOutput("stream_v0", 8'(v0), 8'h1);
                checkOutput("stream_data0", data0, 8'(t - 1));
                checkOutput("stream_data1", data1, 8'(t - 1));
            end
            checkOutput("stream_ready0", 8'(ready0), 8'h1);
            @(posedge clk);
            #1;
        end
        checkOutput("stream_end_v0", 8'(v0), 8'h0);

        // Enqueue and dequeue while full: only dut1 accepts 0x33.
        applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        checkOutput("edf_full0", 8'(ready0), 8'h0);
        checkOutput("edf_full1", 8'(ready1), 8'h0);
        applyStimulus(1'b0, 1'b1, 8'h33, 1'b1, 1'b1);
        checkOutput("edf_ready1", 8'(ready1), 8'h0);
        checkOutput("edf_data1", data1, 8'h22);
        checkOutput("edf_ready0", 8'(ready0), 8'h1);
        checkOutput("edf_data0", data0, 8'h22);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("edf_next_data1", data1, 8'h33);
        checkOutput("edf_next_v1", 8'(v1), 8'h1);
        checkOutput("edf_drop_v0", 8'(v0), 8'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("edf_empty_v1", 8'(v1), 8'h0);

        // Mid-operation reset discards both entries; inputs during reset ignored.
        applyStimulus(1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("mid_full0", 8'(ready0), 8'h0);
        applyStimulus(1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
        checkOutput("mid_rst_v0", 8'(v0), 8'h0);
        checkOutput("mid_rst_ready0", 8'(ready0), 8'h1);
        checkOutput("mid_rst_v1", 8'(v1), 8'h0);
        applyStimulus(1'b0, 1'b1, 8'h7E, 1'b0, 1'b0);
        checkOutput("mid_enq_data0", data0, 8'h7E);
        checkOutput("mid_enq_data1", data1, 8'h7E);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("mid_deq_v0", 8'(v0), 8'h0);

        // Random traffic on dut0 against a queue model; dut1 held in reset.
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic       rv, ry, do_enq;
            logic [7:0] rd;
            rv = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            ry = v0 & 1'($urandom_range(0, 1));
            checkOutput("rand_v0", 8'(v0), 8'(q.size() != 0));
            checkOutput("rand_ready0", 8'(ready0), 8'(q.size() != 2));
            if (ry && q.size() != 0) begin
                checkOutput("rand_data0", data0, q[0]);
            end
            do_enq = rv && (q.size() < 2);
            reset0 = 1'b0;
            reset1 = 1'b1;
            v_i    = rv;
            data_i = rd;
            yumi0  = ry;
            yumi1  = 1'b0;
            @(posedge clk);
            #1;
            if (ry && q.size() != 0) begin
                void'(q.pop_front());
            end
            if (do_enq) begin
                q.push_back(rd);
            end
        end
        while (q.size() != 0) begin
            checkOutput("final_data0", data0, q[0]);
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            void'(q.pop_front());
        end
        checkOutput("final_v0", 8'(v0), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
